// File: rtl/seg7_scan_capture.sv
`default_nettype none
// ============================================================================
//  Module   : seg7_scan_capture
//  Purpose  : Receive side of the multiplexed seven-segment display driver.
//             Samples the scanned anode/cathode lines, waits for each pair to
//             settle, decodes the cathode pattern back to a hex nibble and
//             assembles one four-digit scan frame into a 16-bit word with a
//             single-cycle valid strobe. Error and timeout pulses flag
//             undecodable patterns, illegal anode codes and stalled frames.
//  Revision : 1.0  initial release
// ============================================================================
module seg7_scan_capture #(
   parameter int STABLE_CYCLES  = 1,     // edges a pair must hold (1..15)
   parameter int TIMEOUT_CYCLES = 1024   // idle cycles before a partial frame is dropped (16..65535)
) (
   input  logic        clk,
   input  logic        rst,          // asynchronous, active-low
   input  logic [3:0]  anode,        // one-hot digit select, active-high
   input  logic [6:0]  cathode,      // {g,f,e,d,c,b,a}, active-low
   output logic [15:0] digits,
   output logic [3:0]  blank_mask,
   output logic        frame_valid,
   output logic        seg_err,
   output logic        anode_err,
   output logic        timeout
);

   localparam logic [3:0]  c_stable   = 4'(STABLE_CYCLES);
   localparam logic [15:0] c_tmo_last = 16'(TIMEOUT_CYCLES - 1);
   localparam logic [6:0]  c_blank    = 7'h7F;

   // ------------------------------------------------------------------
   // Input sample stage
   // ------------------------------------------------------------------
   logic [3:0] r_anode;
   logic [6:0] r_cathode;
   logic [3:0] r_prev_anode;
   logic [6:0] r_prev_cathode;

   // Register the raw pins, and keep the previous sample to detect changes.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_anode        <= 4'h0;
         r_cathode      <= c_blank;
         r_prev_anode   <= 4'h0;
         r_prev_cathode <= c_blank;
      end else begin
         r_prev_anode   <= r_anode;
         r_prev_cathode <= r_cathode;
         r_anode        <= anode;
         r_cathode      <= cathode;
      end
   end

   // ------------------------------------------------------------------
   // Stability counter and capture event
   // ------------------------------------------------------------------
   logic [3:0] r_stab;
   logic [3:0] w_stab_next;
   logic       w_changed;
   logic       w_capture;

   // A new sample value reloads the count to 1; an unchanged one counts up
   // and saturates. Capture fires only on the edge the count first lands on
   // the threshold, so a long hold yields exactly one capture.
   always_comb begin
      w_changed   = (r_anode != r_prev_anode) || (r_cathode != r_prev_cathode);
      w_stab_next = r_stab;
      if (w_changed) begin
         w_stab_next = 4'd1;
      end else if (r_stab >= c_stable) begin
         w_stab_next = c_stable;
      end else begin
         w_stab_next = r_stab + 4'd1;
      end
      w_capture = (w_stab_next == c_stable) && (w_changed || (r_stab != c_stable));
   end

   // Stability count register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_stab <= 4'd0;
      end else begin
         r_stab <= w_stab_next;
      end
   end

   // ------------------------------------------------------------------
   // Cathode pattern decode
   // ------------------------------------------------------------------
   logic [3:0] w_dec_val;
   logic       w_dec_ok;
   logic       w_dec_blank;

   // Map each legal active-low segment pattern back to its hex value;
   // all-off is a legal blank digit whose nibble reads as zero.
   always_comb begin
      w_dec_val   = 4'h0;
      w_dec_ok    = 1'b1;
      w_dec_blank = 1'b0;
      case (r_cathode)
         7'h40: w_dec_val = 4'h0;
         7'h79: w_dec_val = 4'h1;
         7'h24: w_dec_val = 4'h2;
         7'h30: w_dec_val = 4'h3;
         7'h19: w_dec_val = 4'h4;
         7'h12: w_dec_val = 4'h5;
         7'h02: w_dec_val = 4'h6;
         7'h78: w_dec_val = 4'h7;
         7'h00: w_dec_val = 4'h8;
         7'h10: w_dec_val = 4'h9;
         7'h08: w_dec_val = 4'hA;
         7'h03: w_dec_val = 4'hB;
         7'h46: w_dec_val = 4'hC;
         7'h21: w_dec_val = 4'hD;
         7'h06: w_dec_val = 4'hE;
         7'h0E: w_dec_val = 4'hF;
         7'h7F: w_dec_blank = 1'b1;
         default: w_dec_ok = 1'b0;
      endcase
   end

   // ------------------------------------------------------------------
   // Slot classification and pending-frame merge
   // ------------------------------------------------------------------
   logic        w_anode_zero;
   logic        w_onehot;
   logic [3:0]  w_seen_set;
   logic        w_complete;
   logic [15:0] r_pend_dig;
   logic [3:0]  r_pend_blank;
   logic [3:0]  r_seen;
   logic [15:0] w_merge_dig;
   logic [3:0]  w_merge_blank;

   // Classify the sampled anode and work out whether this write finishes a frame.
   always_comb begin
      w_anode_zero = (r_anode == 4'h0);
      w_onehot     = !w_anode_zero && ((r_anode & (r_anode - 4'h1)) == 4'h0);
      w_seen_set   = r_seen | r_anode;
      w_complete   = w_capture && w_onehot && w_dec_ok && (w_seen_set == 4'hF);
   end

   // Pending contents with the currently selected slot replaced by the new
   // decode; used both for the pending write and for the frame load so the
   // completing slot appears in the published word on the same edge.
   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_slot
         assign w_merge_dig[4*gi +: 4] = r_anode[gi] ? w_dec_val   : r_pend_dig[4*gi +: 4];
         assign w_merge_blank[gi]      = r_anode[gi] ? w_dec_blank : r_pend_blank[gi];
      end
   endgenerate

   // ------------------------------------------------------------------
   // Frame assembly, error pulses and partial-frame timeout
   // ------------------------------------------------------------------
   logic [15:0] r_tcnt;

   // A capture always takes precedence over the timeout; among captures the
   // anode code is judged before the segment pattern.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_pend_dig   <= 16'h0000;
         r_pend_blank <= 4'h0;
         r_seen       <= 4'h0;
         r_tcnt       <= 16'h0000;
         digits       <= 16'h0000;
         blank_mask   <= 4'h0;
         frame_valid  <= 1'b0;
         seg_err      <= 1'b0;
         anode_err    <= 1'b0;
         timeout      <= 1'b0;
      end else begin
         frame_valid <= 1'b0;
         seg_err     <= 1'b0;
         anode_err   <= 1'b0;
         timeout     <= 1'b0;
         if (w_capture) begin
            r_tcnt <= 16'h0000;
            if (w_anode_zero) begin
               // Display idle or blanked: abandon any partial frame quietly.
               r_seen <= 4'h0;
            end else if (!w_onehot) begin
               anode_err <= 1'b1;
               r_seen    <= 4'h0;
            end else if (!w_dec_ok) begin
               seg_err <= 1'b1;
               r_seen  <= 4'h0;
            end else begin
               r_pend_dig   <= w_merge_dig;
               r_pend_blank <= w_merge_blank;
               if (w_complete) begin
                  digits      <= w_merge_dig;
                  blank_mask  <= w_merge_blank;
                  frame_valid <= 1'b1;
                  r_seen      <= 4'h0;
               end else begin
                  r_seen <= w_seen_set;
               end
            end
         end else if (r_seen == 4'h0) begin
            r_tcnt <= 16'h0000;
         end else if (r_tcnt == c_tmo_last) begin
            timeout <= 1'b1;
            r_seen  <= 4'h0;
            r_tcnt  <= 16'h0000;
         end else begin
            r_tcnt <= r_tcnt + 16'h0001;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_capture.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seg7_scan_capture
//  Purpose  : Directed self-checking bench for seg7_scan_capture. One instance
//             runs with single-edge capture and a short timeout, the other
//             with two-edge capture; both share the same pin stimulus.
//  Revision : 1.0  initial release
// ============================================================================
module tb_seg7_scan_capture;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [3:0]  anode = 4'h0;
   logic [6:0]  cathode = 7'h7F;

   logic [15:0] digits1, digits2;
   logic [3:0]  blank1, blank2;
   logic        fv1, fv2, se1, se2, ae1, ae2, to1, to2;

   int vectors = 0;
   int miscompares = 0;

   logic [3:0] rot_a [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
   logic [6:0] rot_c [4] = '{7'h12, 7'h24, 7'h79, 7'h40};
   logic [6:0] blk_c [4] = '{7'h40, 7'h40, 7'h40, 7'h7F};
   logic [3:0] seg_a [9] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h1, 4'h2, 4'h4, 4'h8, 4'h0};
   logic [6:0] seg_c [9] = '{7'h40, 7'h55, 7'h40, 7'h40, 7'h79, 7'h79, 7'h79, 7'h79, 7'h7F};
   logic [3:0] ae_a  [8] = '{4'h1, 4'h2, 4'h3, 4'h1, 4'h2, 4'h4, 4'h8, 4'h0};
   logic [6:0] ae_c  [8] = '{7'h19, 7'h30, 7'h40, 7'h08, 7'h10, 7'h00, 7'h02, 7'h7F};
   logic [6:0] rs_c  [4] = '{7'h79, 7'h24, 7'h30, 7'h19};

   seg7_scan_capture #(.STABLE_CYCLES(1), .TIMEOUT_CYCLES(16)) u_s1 (
      .clk(clk), .rst(rst), .anode(anode), .cathode(cathode),
      .digits(digits1), .blank_mask(blank1), .frame_valid(fv1),
      .seg_err(se1), .anode_err(ae1), .timeout(to1)
   );

   seg7_scan_capture #(.STABLE_CYCLES(2), .TIMEOUT_CYCLES(1024)) u_s2 (
      .clk(clk), .rst(rst), .anode(anode), .cathode(cathode),
      .digits(digits2), .blank_mask(blank2), .frame_valid(fv2),
      .seg_err(se2), .anode_err(ae2), .timeout(to2)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      if (obs !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [3:0] a, input logic [6:0] c);
      anode   = a;
      cathode = c;
      step();
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) drive(4'h0, 7'h7F);
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_digits1"}, {16'h0, digits1}, 32'h0);
      check({tag, "_blank1"},  {28'h0, blank1}, 32'h0);
      check({tag, "_pulses1"}, {28'h0, fv1, se1, ae1, to1}, 32'h0);
      check({tag, "_digits2"}, {16'h0, digits2}, 32'h0);
      check({tag, "_pulses2"}, {28'h0, fv2, se2, ae2, to2}, 32'h0);
   endtask

   initial begin
      // Reset state
      repeat (3) step();
      check_zero("reset");
      rst = 1'b1;
      idle(3);

      // One-cycle rotation: single-edge instance frames every 4, two-edge never
      for (int i = 0; i < 13; i++) begin
         drive(rot_a[i % 4], rot_c[i % 4]);
         check("rot_fv", {31'h0, fv1}, {31'h0, (i >= 4 && i % 4 == 0)});
         check("rot_err", {29'h0, se1, ae1, to1}, 32'h0);
         check("glitch_fv2", {31'h0, fv2}, 32'h0);
         if (i == 4 || i == 8) begin
            check("rot_digits", {16'h0, digits1}, 32'h0125);
            check("rot_blank", {28'h0, blank1}, 32'h0);
         end
      end
      idle(4);

      // Two-cycle holds: two-edge instance frames every 8 cycles
      for (int n = 0; n < 18; n++) begin
         drive(rot_a[(n / 2) % 4], rot_c[(n / 2) % 4]);
         check("hold2_fv", {31'h0, fv2}, {31'h0, (n >= 8 && n % 8 == 0)});
         if (n == 8 || n == 16) begin
            check("hold2_digits", {16'h0, digits2}, 32'h0125);
            check("hold2_blank", {28'h0, blank2}, 32'h0);
         end
      end
      idle(4);

      // Blank slot 3
      for (int i = 0; i < 5; i++) begin
         if (i < 4) drive(rot_a[i], blk_c[i]);
         else       drive(4'h0, 7'h7F);
         check("blank_fv", {31'h0, fv1}, {31'h0, (i == 4)});
         if (i == 4) begin
            check("blank_digits", {16'h0, digits1}, 32'h0000);
            check("blank_mask", {28'h0, blank1}, 32'h8);
         end
      end
      idle(3);

      // Undecodable pattern on slot 1, then a clean sequence in any order
      for (int i = 0; i < 9; i++) begin
         drive(seg_a[i], seg_c[i]);
         check("seg_err", {31'h0, se1}, {31'h0, (i == 2)});
         check("seg_fv", {31'h0, fv1}, {31'h0, (i == 6)});
         if (i == 6) begin
            check("seg_digits", {16'h0, digits1}, 32'h0011);
            check("seg_blank", {28'h0, blank1}, 32'h0);
         end
      end
      idle(3);

      // Non-one-hot anode mid-frame
      for (int i = 0; i < 8; i++) begin
         drive(ae_a[i], ae_c[i]);
         check("anode_err", {31'h0, ae1}, {31'h0, (i == 3)});
         check("ae_seg", {31'h0, se1}, 32'h0);
         check("ae_fv", {31'h0, fv1}, {31'h0, (i == 7)});
         if (i == 7) check("ae_digits", {16'h0, digits1}, 32'h689A);
      end
      idle(3);

      // Partial frame abandoned by idle: no timeout
      for (int i = 0; i < 24; i++) begin
         if (i < 3) drive(rot_a[i], 7'h40);
         else       drive(4'h0, 7'h7F);
         check("idle_no_tmo", {31'h0, to1}, 32'h0);
      end

      // Partial frame stalled on a held pair: timeout 16 cycles after last capture
      for (int i = 0; i < 25; i++) begin
         if (i < 3) drive(rot_a[i], 7'h40);
         else       drive(4'b0100, 7'h40);
         check("tmo_pulse", {31'h0, to1}, {31'h0, (i == 19)});
         check("tmo_fv", {31'h0, fv1}, 32'h0);
      end
      idle(3);

      // Reset mid-frame, then a fresh frame needs exactly four captures
      for (int i = 0; i < 3; i++) drive(rot_a[i], 7'h40);
      rst = 1'b0;
      #2;
      check_zero("midrst");
      anode   = 4'h0;
      cathode = 7'h7F;
      step();
      step();
      check_zero("midrst_hold");
      rst = 1'b1;
      idle(2);
      for (int i = 0; i < 6; i++) begin
         if (i < 4) drive(rot_a[i], rs_c[i]);
         else       drive(4'h0, 7'h7F);
         check("post_rst_fv", {31'h0, fv1}, {31'h0, (i == 4)});
         if (i == 4) check("post_rst_digits", {16'h0, digits1}, 32'h4321);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
